uart_rx_fifo: RTL

Parametrised UART receiver with an integrated receive FIFO and hardware flow control. It replaces the single-byte receiver and edge-triggered LED latch in the PMOD UART path. It adds configurable data width, optional parity, a first-word-fall-through (FWFT) FIFO, RTS back-pressure, and distinct frame, parity and overrun error reporting. All logic runs in the `clk` domain, with no derived clocks.

---
 rtl/uart_rx_fifo.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// UART receiver (configurable width/parity) feeding a first-word-fall-through
// FIFO with registered RTS back-pressure and one-cycle error pulses.
module uart_rx_fifo #(
  parameter int unsigned CLK_HZ     = 12000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned RTS_THRESH = FIFO_DEPTH - 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        rx,
  output logic                        rts_n,
  output logic [DATA_BITS-1:0]        rd_data,
  output logic                        rd_valid,
  input  logic                        rd_en,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic                        frame_err,
  output logic                        parity_err,
  output logic                        overrun
);

  localparam int unsigned BIT_CYC  = CLK_HZ / BAUD;
  localparam int unsigned HALF_CYC = BIT_CYC / 2;
  localparam int unsigned TMR_W    = $clog2(BIT_CYC);
  localparam int unsigned IDX_W    = $clog2(DATA_BITS) + 1;
  localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W    = PTR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  logic                 r_sync0;
  logic                 r_sync1;
  logic [1:0]           r_settle;
  logic                 r_armed;
  logic                 w_rxs;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [TMR_W-1:0]     r_tmr;
  logic [TMR_W-1:0]     w_tmr_nxt;
  logic [IDX_W-1:0]     r_idx;
  logic [IDX_W-1:0]     w_idx_nxt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] w_shift_nxt;
  logic                 r_par_bad;
  logic                 w_par_bad_nxt;
  logic                 w_tick;
  logic                 w_push;
  logic                 w_frame_err;
  logic                 w_parity_err;

  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [PTR_W-1:0]     w_rd_ptr_nxt;
  logic [CNT_W-1:0]     r_count;
  logic [CNT_W-1:0]     w_count_nxt;
  logic [DATA_BITS-1:0] r_rd_data;
  logic [DATA_BITS-1:0] w_head_nxt;
  logic                 w_full;
  logic                 w_pop;
  logic                 w_wr_en;
  logic                 w_overrun;
  logic                 r_rts_n;
  logic                 r_frame_err;
  logic                 r_parity_err;
  logic                 r_overrun;

  assign w_rxs = r_sync1;

  // r_settle keeps the receiver disarmed until the synchroniser holds real
  // post-reset samples, so a line held low through reset is never decoded.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync0  <= 1'b1;
      r_sync1  <= 1'b1;
      r_settle <= 2'b00;
      r_armed  <= 1'b0;
    end else begin
      r_sync0  <= rx;
      r_sync1  <= r_sync0;
      r_settle <= {r_settle[0], 1'b1};
      r_armed  <= r_armed | (r_settle[1] & w_rxs);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_tmr     <= '0;
      r_idx     <= '0;
      r_shift   <= '0;
      r_par_bad <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_tmr     <= w_tmr_nxt;
      r_idx     <= w_idx_nxt;
      r_shift   <= w_shift_nxt;
      r_par_bad <= w_par_bad_nxt;
    end
  end

  assign w_tick = (r_tmr == TMR_W'(BIT_CYC - 1));

  always_comb begin
    w_state_nxt   = r_state;
    w_tmr_nxt     = r_tmr + TMR_W'(1);
    w_idx_nxt     = r_idx;
    w_shift_nxt   = r_shift;
    w_par_bad_nxt = r_par_bad;
    w_push        = 1'b0;
    w_frame_err   = 1'b0;
    w_parity_err  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_tmr_nxt = '0;
        if (r_armed && !w_rxs) w_state_nxt = S_START;
      end
      S_START: begin
        // Mid-start-bit check; a line back high here is a glitch, not a frame.
        if (r_tmr == TMR_W'(HALF_CYC - 1)) begin
          w_tmr_nxt     = '0;
          w_idx_nxt     = '0;
          w_par_bad_nxt = 1'b0;
          w_state_nxt   = w_rxs ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (w_tick) begin
          w_tmr_nxt   = '0;
          w_shift_nxt = {w_rxs, r_shift[DATA_BITS-1:1]};
          w_idx_nxt   = r_idx + IDX_W'(1);
          if (r_idx == IDX_W'(DATA_BITS - 1))
            w_state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (w_tick) begin
          w_tmr_nxt     = '0;
          w_par_bad_nxt = (^r_shift) ^ w_rxs ^ (PARITY == 1);
          w_state_nxt   = S_STOP;
        end
      end
      S_STOP: begin
        if (w_tick) begin
          w_tmr_nxt = '0;
          if (w_rxs) begin
            w_parity_err = r_par_bad;
            w_push       = !r_par_bad;
            w_state_nxt  = S_IDLE;
          end else begin
            w_frame_err = 1'b1;
            w_state_nxt = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        w_tmr_nxt = '0;
        if (w_rxs) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_pop     = rd_en && (r_count != '0);
  assign w_wr_en   = w_push && (!w_full || w_pop);
  assign w_overrun = w_push && w_full && !w_pop;

  assign w_rd_ptr_nxt = w_pop ? r_rd_ptr + PTR_W'(1) : r_rd_ptr;

  // Next head bypasses the array when this cycle's write lands on it.
  assign w_head_nxt = (w_wr_en && (r_wr_ptr == w_rd_ptr_nxt)) ? r_shift
                                                              : r_mem[w_rd_ptr_nxt];

  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr_en, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= r_shift;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_rd_data    <= '0;
      r_rts_n      <= 1'b1;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      r_rd_ptr     <= w_rd_ptr_nxt;
      r_count      <= w_count_nxt;
      r_rd_data    <= w_head_nxt;
      r_rts_n      <= (r_count >= CNT_W'(RTS_THRESH));
      r_frame_err  <= w_frame_err;
      r_parity_err <= w_parity_err;
      r_overrun    <= w_overrun;
    end
  end

  assign rts_n      = r_rts_n;
  assign rd_data    = r_rd_data;
  assign rd_valid   = (r_count != '0);
  assign count      = r_count;
  assign frame_err  = r_frame_err;
  assign parity_err = r_parity_err;
  assign overrun    = r_overrun;

endmodule
